// File: rtl/composite_sync_decoder.sv
// Sync separator for an 8-bit composite stream: slices, de-glitches and classifies sync pulses.
// Latency: filtered sync lags video by 3 samples; strobes fire 1 cycle after the filtered trailing edge.
// Backpressure: none; one sample is consumed every clock and nothing can stall the stream.
module composite_sync_decoder #(
  parameter int SYNC_THRESHOLD = 26,
  parameter int SYNC_HYST      = 4,
  parameter int GLITCH         = 3,
  parameter int EQ_MAX         = 80,
  parameter int HSYNC_MIN      = 96,
  parameter int HSYNC_MAX      = 160,
  parameter int VSYNC_MIN      = 400,
  parameter int LINE_TOL       = 8,
  parameter int BP_OFFSET      = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  video,
  output logic        sync,
  output logic        newline,
  output logic        newframe,
  output logic        field,
  output logic [9:0]  line_count,
  output logic [11:0] line_period,
  output logic        locked,
  output logic [7:0]  black_level,
  output logic        pulse_error
);

  localparam int GW = $clog2(GLITCH + 1);

  logic          raw_q;
  logic          raw_nxt;
  logic [GW-1:0] glitch_cnt;
  logic [11:0]   width_cnt;
  logic [11:0]   period_cnt;
  logic [2:0]    broad_cnt;
  logic [3:0]    stable_cnt;
  logic          bp_active;
  logic [9:0]    bp_sum;

  logic          flip;
  logic          lead;
  logic          trail;
  logic          hs_evt;
  logic          br_evt;
  logic          err_evt;
  logic          in_tol;
  logic          timeout;
  logic [11:0]   per_diff;

  // Slicer with hysteresis: between the two levels the previous decision is held.
  always_comb begin
    raw_nxt = raw_q;
    if (int'(video) < SYNC_THRESHOLD)
      raw_nxt = 1'b1;
    else if (int'(video) >= SYNC_THRESHOLD + SYNC_HYST)
      raw_nxt = 1'b0;
  end

  // Edge detection, pulse classification and line-period comparison.
  always_comb begin
    flip     = (raw_q != sync) && (glitch_cnt == GW'(GLITCH - 1));
    lead     = flip && !sync;
    trail    = flip && sync;
    hs_evt   = trail && (width_cnt >= 12'(HSYNC_MIN)) && (width_cnt <= 12'(HSYNC_MAX));
    br_evt   = trail && (width_cnt >= 12'(VSYNC_MIN));
    err_evt  = trail && (width_cnt > 12'(EQ_MAX)) && !hs_evt && !br_evt;
    per_diff = (period_cnt >= line_period) ? (period_cnt - line_period)
                                           : (line_period - period_cnt);
    in_tol   = per_diff <= 12'(LINE_TOL);
    timeout  = {1'b0, period_cnt} > {line_period, 1'b0};
  end

  // Glitch filter: sync follows raw only after GLITCH consecutive disagreeing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_q      <= 1'b0;
      sync       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      raw_q <= raw_nxt;
      if (raw_q == sync) begin
        glitch_cnt <= '0;
      end else if (flip) begin
        sync       <= raw_q;
        glitch_cnt <= '0;
      end else begin
        glitch_cnt <= glitch_cnt + 1'b1;
      end
    end
  end

  // Pulse width: counts the cycles sync is high, so the trailing edge sees the full width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      width_cnt <= '0;
    else if (lead)
      width_cnt <= 12'd1;
    else if (sync && width_cnt != 12'hFFF)
      width_cnt <= width_cnt + 12'd1;
  end

  // Line/frame bookkeeping on classified pulses; three broad pulses arm the next newframe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      newline     <= 1'b0;
      newframe    <= 1'b0;
      pulse_error <= 1'b0;
      field       <= 1'b0;
      line_count  <= '0;
      broad_cnt   <= '0;
    end else begin
      newline     <= hs_evt;
      newframe    <= hs_evt && (broad_cnt >= 3'd3);
      pulse_error <= err_evt;
      if (hs_evt) begin
        broad_cnt <= '0;
        if (broad_cnt >= 3'd3) begin
          field      <= ~field;
          line_count <= '0;
        end else if (line_count != 10'h3FF) begin
          line_count <= line_count + 10'd1;
        end
      end else if (br_evt && broad_cnt != 3'd7) begin
        broad_cnt <= broad_cnt + 3'd1;
      end
    end
  end

  // Period measurement and lock; a real hsync outranks a coincident timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt  <= '0;
      line_period <= '0;
      stable_cnt  <= '0;
      locked      <= 1'b0;
    end else if (hs_evt) begin
      line_period <= period_cnt;
      period_cnt  <= 12'd1;
      if (in_tol) begin
        stable_cnt <= (stable_cnt == 4'd8) ? 4'd8 : stable_cnt + 4'd1;
        locked     <= stable_cnt >= 4'd7;
      end else begin
        stable_cnt <= '0;
        locked     <= 1'b0;
      end
    end else begin
      if (period_cnt != 12'hFFF)
        period_cnt <= period_cnt + 12'd1;
      if (timeout) begin
        stable_cnt <= '0;
        locked     <= 1'b0;
      end
    end
  end

  // Back-porch black level: average four samples; any new sync pulse abandons the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_active   <= 1'b0;
      bp_sum      <= '0;
      black_level <= '0;
    end else if (lead) begin
      bp_active <= 1'b0;
    end else if (hs_evt) begin
      bp_active <= 1'b1;
    end else if (bp_active) begin
      if (period_cnt == 12'(BP_OFFSET))
        bp_sum <= {2'b00, video};
      else if (period_cnt > 12'(BP_OFFSET) && period_cnt <= 12'(BP_OFFSET + 3))
        bp_sum <= bp_sum + {2'b00, video};
      else if (period_cnt == 12'(BP_OFFSET + 4)) begin
        black_level <= bp_sum[9:2];
        bp_active   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_composite_sync_decoder.sv
// Directed bench for composite_sync_decoder: slicer glitches, pulse classes, lock, black level, frames, reset.
// Video is driven on the falling edge and outputs are observed on the falling edge.
// The filtered sync lags the video by 3 samples, so back-porch offset k is video sample k+3 after the first black sample.
module tb_composite_sync_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  video;
  logic        sync;
  logic        newline;
  logic        newframe;
  logic        field;
  logic [9:0]  line_count;
  logic [11:0] line_period;
  logic        locked;
  logic [7:0]  black_level;
  logic        pulse_error;

  int checks = 0;
  int errors = 0;

  int nl_cnt = 0;
  int nf_cnt = 0;
  int pe_cnt = 0;
  int sr_cnt = 0;
  int lc_at_nl = -1;
  int lk_at_nl = -1;
  logic sync_d = 1'b0;

  always #5 clk = ~clk;

  composite_sync_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .video       (video),
    .sync        (sync),
    .newline     (newline),
    .newframe    (newframe),
    .field       (field),
    .line_count  (line_count),
    .line_period (line_period),
    .locked      (locked),
    .black_level (black_level),
    .pulse_error (pulse_error)
  );

  // Event counters for strobes and sync rising edges.
  always @(negedge clk) begin
    sync_d <= sync;
    if (sync && !sync_d) sr_cnt <= sr_cnt + 1;
    if (newline) begin
      nl_cnt   <= nl_cnt + 1;
      lc_at_nl <= int'(line_count);
      lk_at_nl <= int'(locked);
    end
    if (newframe)    nf_cnt <= nf_cnt + 1;
    if (pulse_error) pe_cnt <= pe_cnt + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      video = v;
    end
  endtask

  // One 1728-clock line: 127-clock sync tip then black at 52.
  task automatic line_plain();
    drive(8'd0, 127);
    drive(8'd52, 1601);
  endtask

  // Line whose back-porch offsets 40..43 carry the given samples.
  task automatic line_bp(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    drive(8'd0, 127);
    drive(8'd52, 43);
    drive(a, 1);
    drive(b, 1);
    drive(c, 1);
    drive(d, 1);
    drive(8'd52, 1601 - 47);
  endtask

  // Line with a short equalizing pulse landing inside the back-porch window.
  task automatic line_abort();
    drive(8'd0, 127);
    drive(8'd52, 41);
    drive(8'd0, 10);
    drive(8'd52, 1601 - 51);
  endtask

  task automatic broad(input int n);
    for (int i = 0; i < n; i++) begin
      drive(8'd0, 1000);
      drive(8'd52, 200);
    end
  endtask

  int nl0, nf0, pe0, sr0;
  int widths [5] = '{80, 96, 160, 161, 400};
  int exp_nl [5] = '{0, 1, 1, 0, 0};
  int exp_pe [5] = '{0, 0, 0, 1, 0};

  initial begin
    video = 8'd0;
    reset = 1'b1;
    drive(8'd0, 5);
    chk("rst_sync", int'(sync), 0);
    chk("rst_newline", int'(newline), 0);
    chk("rst_newframe", int'(newframe), 0);
    chk("rst_field", int'(field), 0);
    chk("rst_line_count", int'(line_count), 0);
    chk("rst_line_period", int'(line_period), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_black", int'(black_level), 0);
    chk("rst_perr", int'(pulse_error), 0);
    video = 8'd52;
    reset = 1'b0;
    drive(8'd52, 20);

    // Glitch filter: 2-sample dip ignored, 3-sample dip passes as an equalizing pulse.
    nl0 = nl_cnt; pe0 = pe_cnt; sr0 = sr_cnt;
    drive(8'd0, 2);
    drive(8'd52, 20);
    chk("dip2_sync_rise", sr_cnt - sr0, 0);
    chk("dip2_newline", nl_cnt - nl0, 0);
    chk("dip2_perr", pe_cnt - pe0, 0);
    sr0 = sr_cnt;
    drive(8'd0, 3);
    drive(8'd52, 20);
    chk("dip3_sync_rise", sr_cnt - sr0, 1);
    chk("dip3_perr", pe_cnt - pe0, 0);
    chk("dip3_newline", nl_cnt - nl0, 0);
    chk("dip3_sync_low", int'(sync), 0);

    // Pulse width classification boundaries.
    for (int k = 0; k < 5; k++) begin
      nl0 = nl_cnt; pe0 = pe_cnt;
      drive(8'd0, widths[k]);
      drive(8'd52, 300);
      chk($sformatf("w%0d_newline", widths[k]), nl_cnt - nl0, exp_nl[k]);
      chk($sformatf("w%0d_perr", widths[k]), pe_cnt - pe0, exp_pe[k]);
    end

    // Fresh start, then a steady 1728-clock line stream.
    @(negedge clk);
    reset = 1'b1;
    drive(8'd52, 3);
    reset = 1'b0;
    nl0 = nl_cnt;
    for (int k = 1; k <= 10; k++) begin
      line_plain();
      if (k == 8) chk("lock_after8", int'(locked), 0);
    end
    chk("lock_after10", int'(locked), 1);
    chk("lines10_newline", nl_cnt - nl0, 10);
    chk("lines10_count", int'(line_count), 10);
    chk("lines10_period", int'(line_period), 1728);
    chk("black_plain", int'(black_level), 52);
    line_bp(8'd60, 8'd60, 8'd60, 8'd60);
    chk("black_const60", int'(black_level), 60);
    line_plain();
    chk("black_back52", int'(black_level), 52);
    line_bp(8'd58, 8'd60, 8'd61, 8'd63);
    chk("black_mix", int'(black_level), 60);
    line_abort();
    chk("black_abort_kept", int'(black_level), 60);
    chk("lines14_count", int'(line_count), 14);
    chk("lines14_locked", int'(locked), 1);

    // Missing sync: lock holds until the period counter passes 2*1728.
    nl0 = nl_cnt;
    drive(8'd52, 1800);
    chk("timeout_before", int'(locked), 1);
    drive(8'd52, 100);
    chk("timeout_after", int'(locked), 0);
    drive(8'd52, 2100);
    chk("timeout_period", int'(line_period), 1728);
    chk("timeout_newline", nl_cnt - nl0, 0);

    // Vertical intervals: two broad pulses are not enough, three or more start a frame.
    nf0 = nf_cnt;
    broad(2);
    line_plain();
    chk("broad2_newframe", nf_cnt - nf0, 0);
    chk("broad2_count", int'(line_count), 15);
    broad(3);
    line_plain();
    chk("broad3_newframe", nf_cnt - nf0, 1);
    chk("broad3_field", int'(field), 1);
    chk("broad3_count", int'(line_count), 0);
    for (int k = 0; k < 3; k++) line_plain();
    chk("field1_count", int'(line_count), 3);
    broad(5);
    line_plain();
    chk("broad5_newframe", nf_cnt - nf0, 2);
    chk("broad5_field", int'(field), 0);
    chk("broad5_count", int'(line_count), 0);

    // Reset in the middle of an hsync.
    line_plain();
    drive(8'd0, 60);
    reset = 1'b1;
    #1;
    chk("midrst_sync", int'(sync), 0);
    chk("midrst_count", int'(line_count), 0);
    chk("midrst_period", int'(line_period), 0);
    chk("midrst_black", int'(black_level), 0);
    chk("midrst_newline", int'(newline), 0);
    drive(8'd0, 3);
    reset = 1'b0;
    pe0 = pe_cnt;
    drive(8'd0, 40);
    drive(8'd52, 1601);
    nl0 = nl_cnt;
    line_plain();
    chk("postrst_newline", nl_cnt - nl0, 1);
    chk("postrst_count_at_nl", lc_at_nl, 1);
    chk("postrst_locked_at_nl", lk_at_nl, 0);
    chk("postrst_perr", pe_cnt - pe0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
